// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port: the sequencer issues req/write/address-select
// and the memory answers with ready.
interface multicycle_sequencer_if;
  logic memReq;
  logic memWrite;
  logic memAddrSel;
  logic memReady;

  modport master (output memReq, output memWrite, output memAddrSel, input memReady);
  modport slave  (input memReq, input memWrite, input memAddrSel, output memReady);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode, execute,
// memory and writeback, arbitrating one shared memory port and counting retirements.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   run,
  input  logic [2:0]             opType,
  input  logic                   zeroFlag,
  multicycle_sequencer_if.master mem,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   pcSrc,
  output logic                   regWrite,
  output logic                   memToReg,
  output logic                   retire,
  output logic                   busError,
  output logic                   illegalOp,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'd2;
  localparam logic [2:0] OP_STORE   = 3'd3;
  localparam logic [2:0] OP_CBRANCH = 3'd4;
  localparam logic [2:0] OP_BTYPE   = 3'd5;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [7:0]             wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   bus_err_q, bus_err_d;
  logic                   illegal_q, illegal_d;

  logic   mem_req, mem_write, mem_addr_sel;
  logic   ir_write, pc_write, pc_src, reg_write, mem_to_reg, retire_c;
  state_t boundary_state;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = '0;
    bus_err_d    = bus_err_q;
    illegal_d    = illegal_q;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    retire_c     = 1'b0;
    // run is only honoured where an instruction has just retired
    boundary_state = run ? FETCH : IDLE;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem.memReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        op_d = opType;
        if (opType == OP_ILLEGAL) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = MEMORY;
          OP_CBRANCH: begin
            pc_write = zeroFlag;
            pc_src   = 1'b1;
            retire_c = 1'b1;
            state_d  = boundary_state;
          end
          OP_BTYPE: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire_c = 1'b1;
            state_d  = boundary_state;
          end
          default: state_d = WRITEBACK;
        endcase
      end
      MEMORY: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write    = (op_q == OP_STORE);
        if (mem.memReady) begin
          if (op_q == OP_STORE) begin
            retire_c = 1'b1;
            state_d  = boundary_state;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        retire_c   = 1'b1;
        state_d    = boundary_state;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, retire_c};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      count_q   <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem.memReq     = mem_req;
  assign mem.memWrite   = mem_write;
  assign mem.memAddrSel = mem_addr_sel;
  assign irWrite        = ir_write;
  assign pcWrite        = pc_write;
  assign pcSrc          = pc_src;
  assign regWrite       = reg_write;
  assign memToReg       = mem_to_reg;
  assign retire         = retire_c;
  assign busError       = bus_err_q;
  assign illegalOp      = illegal_q;
  assign state          = state_q;
  assign instrCount     = count_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control sequencer for the processor. It steps each instruction through fetch, decode, execute, memory and writeback. It takes opType from the existing decoder and zeroFlag from the ALU, and arbitrates one shared instruction/data memory port using a req/ready handshake. It drives the PC, IR, register-file and memory enables, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, consecutive wait cycles with memReq=1 and memReady=0 before bus error (legal range 1..255)
COUNT_WIDTH, 16, width of the retired-instruction counter

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
run  input  1  1 = keep issuing instructions; sampled at instruction boundaries
opType  input  3  decoder class: 0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 CBRANCH, 5 BTYPE, 6 MOV, 7 illegal
zeroFlag  input  1  ALU zero result, valid in EXECUTE
memReady  input  1  memory completes the current request this cycle
memReq  output  1  memory request
memWrite  output  1  1 = write request (STORE only)
memAddrSel  output  1  0 = PC address, 1 = ALU result address
irWrite  output  1  load instruction register
pcWrite  output  1  update PC
pcSrc  output  1  0 = PC+4, 1 = branch target
regWrite  output  1  register-file write enable
memToReg  output  1  writeback source: 1 = memory data, 0 = ALU
retire  output  1  one-cycle pulse when an instruction completes
busError  output  1  sticky: memory timeout occurred
illegalOp  output  1  sticky: opType 7 decoded
state  output  3  current state encoding, for debug
instrCount  output  COUNT_WIDTH  retired-instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. One state register; control outputs are combinational from state, latched opType and inputs.
- Reset (rstN=0, asynchronous): state=IDLE; instrCount=0; waitCount=0; opReg=0; busError=0; illegalOp=0. All control outputs are 0 immediately, including memReq mid-transaction.
- "next" means FETCH if run=1, else IDLE.
- IDLE: all enables 0; run=1 -> FETCH.
- FETCH: memReq=1, memAddrSel=0, memWrite=0.
  - memReady=1: irWrite=1, pcWrite=1, pcSrc=0 in that same cycle; -> DECODE.
- DECODE: latch opType into opReg; exactly 1 cycle.
  - opType=7 -> HALT, set illegalOp; else -> EXECUTE.
- EXECUTE: exactly 1 cycle; branches by opReg:
  - LOAD/STORE -> MEMORY.
  - CBRANCH: pcWrite=zeroFlag, pcSrc=1, retire=1 -> next.
  - BTYPE: pcWrite=1, pcSrc=1, retire=1 -> next.
  - RTYPE/ITYPE/MOV -> WRITEBACK.
- MEMORY: memReq=1, memAddrSel=1, memWrite=(opReg==STORE).
  - memReady=1 and STORE: retire=1 -> next.
  - memReady=1 and LOAD -> WRITEBACK.
- WRITEBACK: regWrite=1, memToReg=(opReg==LOAD), retire=1; exactly 1 cycle -> next.
- HALT: all enables 0; busError/illegalOp stay set; exits only via reset.
- Timeout:
  - waitCount increments each FETCH/MEMORY cycle with memReady=0; clears on memReady=1 or leaving the state.
  - waitCount==MEM_TIMEOUT-1 with memReady=0 -> HALT, busError=1. The request is dropped after exactly MEM_TIMEOUT wait cycles.
  - memReady=1 in the terminal wait cycle wins: normal transition, no error.
- Latency with zero-wait memory: branch 3 cycles; ALU op 4; store 4; load 5.
- instrCount increments by 1 on each retire and wraps 2^COUNT_WIDTH-1 -> 0.
- run=0 mid-instruction: the instruction completes; IDLE is entered at the boundary.

Test Plan:
- Reset mid-MEMORY: assert rstN=0 while memReq=1 -> memReq=0 the same cycle; state=0; instrCount=0.
- run=1, memReady always 1, opType=0 -> states 1,2,3,5 repeat; retire every 4th cycle; regWrite=1 in state 5; after 3 instructions instrCount=3.
- opType=2 (LOAD), memReady=1 in FETCH, held 0 for 3 cycles in MEMORY then 1 -> WRITEBACK with memToReg=1; 8 cycles FETCH-to-retire; busError=0.
- opType=4: zeroFlag=1 -> pcWrite=1, pcSrc=1 in EXECUTE; zeroFlag=0 -> pcWrite=0. retire=1 in both cases.
- MEM_TIMEOUT=15, memReady stuck 0 in FETCH -> HALT after 15 cycles, busError=1, memReq=0. Repeat with memReady=1 on the 15th cycle -> DECODE, no error.
- opType=7 -> HALT after DECODE, illegalOp=1, instrCount unchanged. COUNT_WIDTH=4 with 17 retires -> instrCount=1.
